// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory loader.
// The instruction memory and decoder use the same NOP/END encodings.
package imem_pkg;

    localparam logic [31:0] NOP_WORD   = 32'hF800_0000;
    localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
    localparam logic [4:0]  OPCODE_NOP = 5'b11111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } loader_state_t;

    // True when a word is the image terminator.
    function automatic logic is_end_word(input logic [31:0] w);
        return w == END_WORD;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = byte source / memory side, slave = loader side.
interface imem_loader_if #(
    parameter int AW = 5
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Collects big-endian bytes into 32-bit words. The fourth byte is not
// stored: the word is presented combinationally together with a one-cycle
// word_valid pulse on the handshake that completes it.
module byte_assembler
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        hs,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  bc_q, bc_d;
    logic [23:0] shift_q, shift_d;
    logic [23:0] shifted;

    // Byte lanes of the shift register after accepting one more byte.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        if (gi == 0) begin : g_first
            assign shifted[7:0] = in_byte;
        end else begin : g_next
            assign shifted[8*gi +: 8] = shift_q[8*(gi-1) +: 8];
        end
    end

    assign word       = {shift_q, in_byte};
    assign word_valid = hs & (bc_q == 2'd3);

    // Next byte count / shift contents; clear wins over a handshake.
    always_comb begin
        bc_d    = bc_q;
        shift_d = shift_q;
        if (clear) begin
            bc_d    = 2'd0;
            shift_d = 24'd0;
        end else if (hs) begin
            bc_d    = bc_q + 2'd1;
            shift_d = shifted;
        end
    end

    // Counter and shift register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            bc_q    <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            bc_q    <= bc_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: writes a streamed image into instruction memory from
// address 0, pads the remainder with NOPs and holds the core in stall
// (busy) until the image is complete.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5    // DEPTH must not exceed 2**AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_count
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    loader_state_t state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW:0]   count_q, count_d;
    // Set when the write now being presented is the last one; the next
    // cycle moves to DONE so wr_en is never high in DONE.
    logic          final_q, final_d;

    logic          start_ok;
    logic          hs;
    logic [31:0]   asm_word;
    logic          asm_valid;

    assign start_ok = start & ((state_q == IDLE) | (state_q == DONE));
    assign hs       = bus.in_valid & (state_q == LOAD);

    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .hs         (hs),
        .in_byte    (bus.in_data),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    // Next-state, address and write-register logic.
    // The final write issued from LOAD (END at the last address, or an
    // overflow) parks in FILL with final set: in_ready drops immediately
    // and DONE follows once the write has been presented.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        err_d     = err_q;
        count_d   = count_q;
        final_d   = final_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    final_d = 1'b0;
                end
            end
            LOAD: begin
                if (asm_valid) begin
                    count_d   = count_q + (AW+1)'(1);
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    if (is_end_word(asm_word)) begin
                        wr_data_d = END_WORD;
                        state_d   = FILL;
                        if (addr_q == LAST_ADDR) begin
                            final_d = 1'b1;
                        end else begin
                            addr_d = addr_q + AW'(1);
                        end
                    end else if (addr_q != LAST_ADDR) begin
                        wr_data_d = asm_word;
                        addr_d    = addr_q + AW'(1);
                    end else begin
                        // No room left for END: force it into the last slot.
                        wr_data_d = END_WORD;
                        err_d     = 1'b1;
                        state_d   = FILL;
                        final_d   = 1'b1;
                    end
                end
            end
            FILL: begin
                if (final_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    final_d = 1'b0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = NOP_WORD;
                    if (addr_q == LAST_ADDR) begin
                        final_d = 1'b1;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Loader state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 32'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
            final_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            count_q   <= count_d;
            final_q   <= final_d;
        end
    end

    assign bus.in_ready = (state_q == LOAD);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = (state_q == LOAD) | (state_q == FILL);
    assign done         = done_q;
    assign err          = err_q;
    assign word_count   = count_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader: the write side of the instruction memory port. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Words are written to consecutive instruction-memory addresses starting at 0, up to and including the END word (0xFFFFFFFF). Every remaining address is then padded with NOP (0xF8000000). The core is held in stall (busy=1) until the image is complete.

Parameters:
DEPTH, 32, number of instruction-memory words.
AW, 5, address width; DEPTH must not exceed 2**AW.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE
in_valid  in  1  byte source has data
in_data  in  8  stream byte, most significant byte of each word first
in_ready  out  1  loader accepts a byte this cycle
wr_en  out  1  instruction-memory write strobe
wr_addr  out  AW  write address
wr_data  out  32  write word
busy  out  1  load or fill in progress; core PC must stall
done  out  1  image complete; level, held until next start or reset
err  out  1  overflow: image had no END before the last address
word_count  out  AW+1  words received from the stream, including END

Behaviour:
- Reset (synchronous, rst=1 at a clock edge): state=IDLE. wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, word_count=0. Byte counter and shift register are cleared. Reset mid-load discards any partial word; no write strobe is issued in the cycle after reset.
- States:
  - IDLE: nothing happens until start.
  - LOAD: accepting bytes.
  - FILL: writing NOP padding.
  - DONE: image complete.
- Transitions:
  - IDLE or DONE + start -> LOAD. Clears address, byte counter, word_count, err and done.
  - start in LOAD or FILL is ignored.
- in_ready = 1 only in LOAD. It is a Moore output decoded from state, not from in_valid.
- A byte handshake is in_valid & in_ready. Byte counter bc counts 0..3. Shift register holds the prior three bytes; word = {shift[23:0], in_data}.
- On the handshake with bc=3 (word complete), word_count increments. The next cycle has wr_en=1 with the registered addr/data (one-cycle latency from the final byte). Then:
  - word != END and addr < DEPTH-1: write word at addr, addr+1, stay in LOAD.
  - word == END: write END at addr. If addr == DEPTH-1 -> DONE; else -> FILL starting at addr+1.
  - word != END and addr == DEPTH-1: write END (not the received word) at DEPTH-1, set err=1, -> DONE.
- FILL:
  - in_ready=0.
  - One NOP write per cycle at increasing addr.
  - After the write to DEPTH-1, go to DONE.
- DONE: done=1 starting the cycle after the final write. busy=0.
- busy=1 in LOAD and FILL. wr_en is never asserted in IDLE or DONE.
- Address arithmetic: AW bits, never wraps; it is bounded by the DEPTH-1 checks.
- in_valid=1 while not in LOAD: the byte is not consumed and no state changes.
- Stalled source (in_valid=0) in LOAD: the partial word is held indefinitely.

Decomposition:
Shared package (imem_pkg):
- NOP_WORD = 32'hF800_0000
- END_WORD = 32'hFFFF_FFFF
- OPCODE_NOP = 5'b11111
- loader state enum {IDLE, LOAD, FILL, DONE}

The same constants are used by the instruction memory/decoder. One sub-module: byte_assembler, which holds the 2-bit byte counter and shift register, takes handshake and byte, emits word + word_valid pulse, and has a clear input. The FSM, address counter and write register live in imem_loader.

Test Plan:
1. DEPTH=8, start, then bytes 10 42 00 01, 10 84 00 03, FF FF FF FF with in_valid held high.
   - Required writes: addr0=0x10420001, addr1=0x10840003, addr2=0xFFFFFFFF, addr3..7=0xF8000000 on consecutive cycles.
   - done the cycle after the addr7 write; word_count=3; err=0.
2. Same image with in_valid toggling 1/0 every cycle.
   - Identical write sequence, with each wr_en exactly one cycle after the 4th-byte handshake.
   - in_ready stays 1 throughout LOAD.
3. DEPTH=8, stream of 8 non-END words.
   - Addr0..6 get the stream words; addr7 = 0xFFFFFFFF.
   - err=1, done=1, word_count=8, in_ready=0 afterwards.
4. rst asserted after 2 bytes of word 1 (word 0 already written).
   - Next cycle: state IDLE, wr_en=0, outputs at reset values.
   - A new start + full image reloads from addr0 with no stale bytes.
5. start pulsed during LOAD and during FILL.
   - Ignored; the write sequence is unchanged.
   - start in DONE restarts: done drops next cycle, busy=1, word_count=0.
6. END as the first word (FF FF FF FF), DEPTH=8.
   - addr0=END, addr1..7=NOP, done=1, word_count=1.
